// File: rtl/pe_sequencer_if.sv
// Handshake and PE control bundle between top-level control, the sequencer and the processing element.
// The master side is the sequencer; the slave side is the control/PE environment.
interface pe_sequencer_if;
  logic       start;
  logic [7:0] num_outputs;
  logic       data_valid;
  logic       busy;
  logic       done;
  logic [7:0] img_adr;
  logic [7:0] filter_adr;
  logic       rst_acc;
  logic       acc_en;
  logic       res_buffer_en;
  logic [7:0] res_index;
  logic       rst_res_reg;
  logic       wr_en;
  logic [7:0] wr_adr;
  logic       wr_file;

  modport master (
    input  start, num_outputs, data_valid,
    output busy, done, img_adr, filter_adr, rst_acc, acc_en, res_buffer_en,
           res_index, rst_res_reg, wr_en, wr_adr, wr_file
  );

  modport slave (
    output start, num_outputs, data_valid,
    input  busy, done, img_adr, filter_adr, rst_acc, acc_en, res_buffer_en,
           res_index, rst_res_reg, wr_en, wr_adr, wr_file
  );
endinterface

// File: rtl/pe_sequencer.sv
// Sequences one processing element: per output position, NUM_FILTERS windowed accumulations,
// a result-buffer write to memory, and a final file dump.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; latches clamped position count
// S_CLR   | clear MAC accumulator, restart tap counter
// S_ACC   | accumulate one tap per data_valid cycle
// S_CAPT  | capture MAC result into result buffer word f
// S_WRITE | write result buffer to memory at position p
// S_NEXT  | clear result buffer, advance to next position
// S_FLUSH | dump result memory to file
// S_DONE  | one-cycle completion pulse
module pe_sequencer #(
  parameter int FILTER_SIZE  = 16,
  parameter int NUM_FILTERS  = 4,
  parameter int MAX_MEM_SIZE = 128,
  parameter int IMG_STRIDE   = 1
) (
  input  logic            clk,
  input  logic            rst,
  pe_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ACC, S_CAPT, S_WRITE, S_NEXT, S_FLUSH, S_DONE
  } state_t;

  localparam logic [7:0] K_LAST = 8'(FILTER_SIZE - 1);
  localparam logic [7:0] F_LAST = 8'(NUM_FILTERS - 1);
  localparam logic [7:0] P_MAX  = 8'(MAX_MEM_SIZE);
  localparam logic [7:0] STRIDE = 8'(IMG_STRIDE);
  localparam logic [7:0] FSIZE  = 8'(FILTER_SIZE);

  state_t     state, state_d;
  logic [7:0] p, p_d, f, f_d, k, k_d, p_len, p_len_d;

  logic       busy_q, rst_acc_q, res_buffer_en_q, rst_res_reg_q, wr_en_q, wr_file_q, done_q;
  logic [7:0] img_adr_q, filter_adr_q, res_index_q, wr_adr_q;

  logic       busy_d, rst_acc_d, res_buffer_en_d, rst_res_reg_d, wr_en_d, wr_file_d, done_d;
  logic [7:0] img_adr_d, filter_adr_d, res_index_d, wr_adr_d;

  always_comb begin
    state_d = state;
    p_d     = p;
    f_d     = f;
    k_d     = k;
    p_len_d = p_len;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          p_len_d = (bus.num_outputs > P_MAX) ? P_MAX : bus.num_outputs;
          p_d     = 8'd0;
          f_d     = 8'd0;
          k_d     = 8'd0;
          state_d = (p_len_d == 8'd0) ? S_FLUSH : S_CLR;
        end
      end
      S_CLR: begin
        k_d     = 8'd0;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (bus.data_valid) begin
          if (k == K_LAST) state_d = S_CAPT;
          else             k_d     = k + 8'd1;
        end
      end
      S_CAPT: begin
        if (f < F_LAST) begin
          f_d     = f + 8'd1;
          state_d = S_CLR;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        f_d = 8'd0;
        if (p < p_len - 8'd1) begin
          p_d     = p + 8'd1;
          state_d = S_CLR;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with the state.
  always_comb begin
    busy_d          = (state_d != S_IDLE);
    rst_acc_d       = (state_d == S_CLR);
    res_buffer_en_d = (state_d == S_CAPT);
    rst_res_reg_d   = (state_d == S_NEXT);
    wr_en_d         = (state_d == S_WRITE);
    wr_file_d       = (state_d == S_FLUSH);
    done_d          = (state_d == S_DONE);
    res_index_d     = (state_d == S_CAPT) ? f_d : 8'd0;
    wr_adr_d        = (state_d == S_WRITE) ? p_d : 8'd0;
    img_adr_d       = img_adr_q;
    filter_adr_d    = filter_adr_q;
    if (state_d == S_ACC) begin
      img_adr_d    = p_d * STRIDE + k_d;
      filter_adr_d = f_d * FSIZE + k_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      p               <= 8'd0;
      f               <= 8'd0;
      k               <= 8'd0;
      p_len           <= 8'd0;
      busy_q          <= 1'b0;
      rst_acc_q       <= 1'b0;
      res_buffer_en_q <= 1'b0;
      rst_res_reg_q   <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_file_q       <= 1'b0;
      done_q          <= 1'b0;
      img_adr_q       <= 8'd0;
      filter_adr_q    <= 8'd0;
      res_index_q     <= 8'd0;
      wr_adr_q        <= 8'd0;
    end else begin
      state           <= state_d;
      p               <= p_d;
      f               <= f_d;
      k               <= k_d;
      p_len           <= p_len_d;
      busy_q          <= busy_d;
      rst_acc_q       <= rst_acc_d;
      res_buffer_en_q <= res_buffer_en_d;
      rst_res_reg_q   <= rst_res_reg_d;
      wr_en_q         <= wr_en_d;
      wr_file_q       <= wr_file_d;
      done_q          <= done_d;
      img_adr_q       <= img_adr_d;
      filter_adr_q    <= filter_adr_d;
      res_index_q     <= res_index_d;
      wr_adr_q        <= wr_adr_d;
    end
  end

  // acc_en must track data_valid within the same cycle so stalled taps are not accumulated.
  assign bus.acc_en        = (state == S_ACC) && bus.data_valid;
  assign bus.busy          = busy_q;
  assign bus.rst_acc       = rst_acc_q;
  assign bus.res_buffer_en = res_buffer_en_q;
  assign bus.rst_res_reg   = rst_res_reg_q;
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_file       = wr_file_q;
  assign bus.done          = done_q;
  assign bus.img_adr       = img_adr_q;
  assign bus.filter_adr    = filter_adr_q;
  assign bus.res_index     = res_index_q;
  assign bus.wr_adr        = wr_adr_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: a phase-list reference model predicts every cycle of a run and a
// behavioural PE (MAC, result buffer, memory) is checked against a direct convolution.
module tb_pe_sequencer;
  localparam int FS   = 4;
  localparam int NF   = 4;
  localparam int MAXM = 128;
  localparam int STR  = 1;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_sequencer_if bus();

  pe_sequencer #(.FILTER_SIZE(FS), .NUM_FILTERS(NF), .MAX_MEM_SIZE(MAXM), .IMG_STRIDE(STR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    byte ph;
    int  p;
    int  f;
    int  k;
  } step_t;

  step_t       sched[$];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  img_mem  [256];
  logic [7:0]  filt_mem [256];
  logic [31:0] acc;
  logic [31:0] rbuf    [NF];
  logic [31:0] res_mem [MAXM][NF];
  logic [7:0]  exp_img, exp_filt;

  // Behavioural processing element driven by the sequencer strobes.
  always @(posedge clk) begin
    if (bus.rst_acc) acc <= 32'd0;
    else if (bus.acc_en) acc <= acc + 32'(img_mem[bus.img_adr]) * 32'(filt_mem[bus.filter_adr]);
    if (bus.rst_res_reg) begin
      for (int i = 0; i < NF; i++) rbuf[i] <= 32'd0;
    end else if (bus.res_buffer_en) begin
      rbuf[bus.res_index[1:0]] <= acc;
    end
    if (bus.wr_en) begin
      for (int i = 0; i < NF; i++) res_mem[bus.wr_adr[6:0]][i] <= rbuf[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {bus.busy, bus.rst_acc, bus.acc_en, bus.res_buffer_en,
            bus.rst_res_reg, bus.wr_en, bus.wr_file, bus.done};
  endfunction

  task automatic build(input int np);
    step_t s;
    sched.delete();
    for (int p = 0; p < np; p++) begin
      for (int f = 0; f < NF; f++) begin
        s = '{"C", p, f, 0}; sched.push_back(s);
        for (int k = 0; k < FS; k++) begin
          s = '{"A", p, f, k}; sched.push_back(s);
        end
        s = '{"K", p, f, 0}; sched.push_back(s);
      end
      s = '{"W", p, 0, 0}; sched.push_back(s);
      s = '{"N", p, 0, 0}; sched.push_back(s);
    end
    s = '{"F", 0, 0, 0}; sched.push_back(s);
    s = '{"D", 0, 0, 0}; sched.push_back(s);
  endtask

  task automatic run(input logic [7:0] n, input int stall_pct, input bit noisy_start, input bit reset_mid);
    int np, c, stalls, n_acc, n_wr, done_cyc;
    bit dv, hit_rst;
    step_t s;
    logic [7:0] ev;
    logic [31:0] e;
    np = (int'(n) > MAXM) ? MAXM : int'(n);
    c = 0; stalls = 0; n_acc = 0; n_wr = 0; done_cyc = -1; hit_rst = 0;
    for (int i = 0; i < 256; i++) begin
      img_mem[i]  = 8'($urandom);
      filt_mem[i] = 8'($urandom);
    end
    build(np);
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_outputs = n;
    bus.data_valid = 1'($urandom);
    #1;
    check("idle_before_start", 32'(strobes()), 32'd0);
    while (sched.size() > 0 && c < LIMIT && !hit_rst) begin
      @(negedge clk);
      c++;
      s = sched[0];
      dv = ($urandom_range(99) >= stall_pct);
      bus.data_valid = dv;
      bus.start = noisy_start && (($urandom_range(3) == 0) || s.ph == "D");
      if (reset_mid && s.ph == "A" && s.p == 1 && s.f == 1 && s.k == 2) begin
        rst = 1'b1;
        bus.start = 1'b0;
        hit_rst = 1;
      end
      #1;
      if (s.ph == "A") begin
        exp_img  = 8'(s.p * STR + s.k);
        exp_filt = 8'(s.f * FS + s.k);
      end
      ev = {1'b1, s.ph == "C", s.ph == "A" && dv, s.ph == "K",
            s.ph == "N", s.ph == "W", s.ph == "F", s.ph == "D"};
      check("strobes", 32'(strobes()), 32'(ev));
      check("img_adr", 32'(bus.img_adr), 32'(exp_img));
      check("filter_adr", 32'(bus.filter_adr), 32'(exp_filt));
      if (s.ph == "K") check("res_index", 32'(bus.res_index), 32'(s.f));
      if (s.ph == "W") check("wr_adr", 32'(bus.wr_adr), 32'(s.p));
      if (bus.acc_en === 1'b1) n_acc++;
      if (bus.wr_en === 1'b1) n_wr++;
      if (bus.done === 1'b1) done_cyc = c;
      if (s.ph != "A" || dv) void'(sched.pop_front());
      else stalls++;
    end
    if (hit_rst) begin
      @(negedge clk);
      #1;
      check("rst_strobes", 32'(strobes()), 32'd0);
      check("rst_img_adr", 32'(bus.img_adr), 32'd0);
      check("rst_filter_adr", 32'(bus.filter_adr), 32'd0);
      check("rst_res_index", 32'(bus.res_index), 32'd0);
      check("rst_wr_adr", 32'(bus.wr_adr), 32'd0);
      rst = 1'b0;
      exp_img = 8'd0;
      exp_filt = 8'd0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        #1;
        check("rst_quiet", 32'(strobes()), 32'd0);
      end
      return;
    end
    check("sched_drained", 32'(sched.size()), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.data_valid = 1'b0;
    #1;
    check("idle_after_done", 32'(strobes()), 32'd0);
    check("done_cycle", 32'(done_cyc), 32'(np * (NF * (FS + 2) + 2) + 2 + stalls));
    check("acc_en_count", 32'(n_acc), 32'(np * NF * FS));
    check("wr_en_count", 32'(n_wr), 32'(np));
    for (int p = 0; p < np; p++) begin
      for (int f = 0; f < NF; f++) begin
        e = 32'd0;
        for (int k = 0; k < FS; k++)
          e += 32'(img_mem[(p * STR + k) % 256]) * 32'(filt_mem[(f * FS + k) % 256]);
        check("mem_word", res_mem[p][f], e);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_outputs = 8'd0;
    bus.data_valid = 1'b0;
    exp_img = 8'd0;
    exp_filt = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_strobes", 32'(strobes()), 32'd0);
    check("reset_img_adr", 32'(bus.img_adr), 32'd0);
    check("reset_filter_adr", 32'(bus.filter_adr), 32'd0);
    rst = 1'b0;

    run(8'd1, 0, 1'b0, 1'b0);
    run(8'd2, 0, 1'b0, 1'b0);
    run(8'd3, 25, 1'b0, 1'b0);
    run(8'd0, 0, 1'b0, 1'b0);
    run(8'd200, 10, 1'b0, 1'b0);
    run(8'd3, 0, 1'b0, 1'b1);
    run(8'd2, 0, 1'b0, 1'b0);
    run(8'd2, 0, 1'b1, 1'b0);
    run(8'd0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      run(8'($urandom_range(1, 6)), $urandom_range(0, 40), 1'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
